// File: rtl/adc0820_sequencer.sv
// Sequencer for an ADC0820 in WR-RD mode: scans an external analog mux,
// runs one conversion per period and reports each sample with its channel.
module adc0820_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int WR_CYC  = 20,
  parameter int RD_CYC  = 4,
  parameter int TIMEOUT = 64,
  parameter int PERIOD  = 200
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            single,
  input  logic            start,
  input  logic [7:0]      adc_db,
  input  logic            intr_n,
  output logic            cs_n,
  output logic            wr_n,
  output logic            rd_n,
  output logic [CH_W-1:0] mux_sel,
  output logic [7:0]      data,
  output logic [CH_W-1:0] data_ch,
  output logic            data_valid,
  output logic            timeout_err
);

  localparam int MAX_WR_RD = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int CNT_MAX   = (MAX_WR_RD > TIMEOUT) ? MAX_WR_RD : TIMEOUT;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int PW        = $clog2(PERIOD + 1);

  typedef enum logic [2:0] {IDLE, WR, WAIT, RD, GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   per_cnt;
  logic            intr_meta, intr_sync;
  logic            wr_done, rd_done, wait_expired, per_done;

  assign wr_done      = (state == WR) && (cnt == CW'(WR_CYC - 1));
  assign rd_done      = (state == RD) && (cnt == CW'(RD_CYC - 1));
  assign wait_expired = (state == WAIT) && intr_sync && (cnt == CW'(TIMEOUT - 1));
  assign per_done     = (per_cnt >= PW'(PERIOD - 1));

  // intr_n comes straight from the converter, so it is resynchronized first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      intr_meta <= 1'b1;
      intr_sync <= 1'b1;
    end else begin
      intr_meta <= intr_n;
      intr_sync <= intr_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable && (!single || start)) state_nxt = WR;
      WR:   if (wr_done) state_nxt = WAIT;
      WAIT: begin
        if (!intr_sync)        state_nxt = RD;
        else if (wait_expired) state_nxt = GAP;
      end
      RD:   if (rd_done) state_nxt = GAP;
      GAP:  if (per_done) state_nxt = (enable && !single) ? WR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs_n = 1'b1;
    wr_n = 1'b1;
    rd_n = 1'b1;
    case (state)
      WR: begin
        cs_n = 1'b0;
        wr_n = 1'b0;
      end
      WAIT: cs_n = 1'b0;
      RD: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
      end
      default: ;
    endcase
  end

  // Phase counter restarts on every state change; period counter restarts
  // only on WR entry and saturates so a long idle never wraps it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      per_cnt <= '0;
    end else begin
      if (state_nxt != state || state == IDLE || state == GAP) cnt <= '0;
      else                                                     cnt <= cnt + 1'b1;
      if (state_nxt == WR && state != WR) per_cnt <= '0;
      else if (per_cnt != '1)            per_cnt <= per_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mux_sel     <= '0;
      data        <= '0;
      data_ch     <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid  <= rd_done;
      timeout_err <= wait_expired;
      if (rd_done) begin
        data    <= adc_db;
        data_ch <= mux_sel;
      end
      if (rd_done || wait_expired)
        mux_sel <= (mux_sel == CH_W'(NUM_CH - 1)) ? '0 : mux_sel + 1'b1;
    end
  end

endmodule
